uart_ascii_sender: RTL
======================

// Module: uart_ascii_sender
// PURPOSE
//  Formats a binary sensor reading into an ASCII line: <tag> ':' <decimal digits> CR LF.
//  Pushes the line byte-by-byte into the UART controller TX FIFO (tx_push / tx_push_data / tx_full).
//  Sits directly upstream of uart_controller. Driven by the watch/sensor control FSM.
//  Lets the sensor blocks report distance, temperature and humidity over UART.
// PARAMETERS
//  DATA_W        14  width of value; 2**DATA_W-1 must be < 10**NUM_DIGITS
//  NUM_DIGITS     5  number of BCD digits produced
//  SUPPRESS_ZERO  1  1: drop leading zeros (always send at least one digit); 0: send all NUM_DIGITS digits
// PORTS
//  clk           in   1       system clock
//  rst           in   1       synchronous, active-low reset (rst==0 resets on the clk edge)
//  start         in   1       1-cycle request; value and tag are sampled in this cycle
//  tag           in   8       ASCII tag character, e.g. 8'h44 'D'
//  value         in   DATA_W  unsigned reading to print
//  tx_full       in   1       TX FIFO full, from uart_controller
//  tx_push       out  1       TX FIFO push strobe
//  tx_push_data  out  8       byte to push; valid when tx_push=1
//  busy          out  1       high from the cycle after an accepted start until the frame completes
//  done          out  1       1-cycle pulse after the LF byte is accepted
// BEHAVIOUR
//  Reset (rst==0): state=IDLE; tx_push=0, tx_push_data=8'h00, busy=0, done=0.
//    BCD and shift registers are cleared.
//  States: IDLE -> CONV -> TAG -> SEP -> DIG -> CR -> LF -> IDLE.
//  IDLE:
//    - start=1: latch tag and value, clear BCD, go to CONV. busy=1 from the next cycle.
//    - start is ignored in every other state, no queuing.
//  CONV: iterative double-dabble. Exactly DATA_W cycles, one shift per cycle.
//    - Each cycle, before the shift, add 3 to every BCD nibble that is >=5.
//    - Then go to TAG.
//  Digit pointer, set on leaving CONV:
//    - SUPPRESS_ZERO=1: pointer = most-significant non-zero digit, or digit 0 if value==0.
//    - SUPPRESS_ZERO=0: pointer = NUM_DIGITS-1.
//  Send states:
//    - tx_push = in_send_state & ~tx_full (combinational). The FIFO samples it on the same edge.
//    - tx_push_data = 8'h30+digit in DIG. In TAG/SEP/CR/LF it is tag / 8'h3A / 8'h0D / 8'h0A.
//    - tx_push_data = 8'h00 outside send states.
//    - Advance only on a cycle with tx_push=1.
//    - While tx_full=1: hold state and byte, tx_push=0. No byte is dropped or duplicated.
//  DIG: after each push, step the pointer down. Leave to CR after digit 0 is pushed.
//  Latency with tx_full=0:
//    - First tx_push occurs DATA_W+1 cycles after the start cycle.
//    - All frame bytes are then pushed on consecutive cycles.
//  Completion:
//    - The LF push cycle moves the FSM to IDLE.
//    - In the next cycle done=1 for exactly one cycle and busy=0.
//    - A start in that cycle is accepted.
//  Reset mid-frame:
//    - Abort immediately, with no further pushes.
//    - Bytes already pushed stay in the FIFO and are not retracted. No done pulse.
//  Frame length = 4 + digit count. Maximum 4+NUM_DIGITS bytes.
// TESTING
//  1. tag=8'h44, value=1234, tx_full=0:
//     -> bytes 44 3A 31 32 33 34 0D 0A on 8 consecutive cycles.
//     -> first push 15 cycles after start; then one done pulse.
//  2. value=0 (tag 'T') -> 54 3A 30 0D 0A.
//     value=16383 -> digits 31 36 33 38 33, 9 bytes total.
//  3. tx_full held high 20 cycles while the 2nd digit is pending:
//     -> tx_push=0 and tx_push_data stable throughout.
//     -> on release the same byte is pushed once and the frame completes intact.
//  4. start pulse with value=99 while busy:
//     -> ignored; the frame in progress is unchanged.
//     start in the done cycle -> a new frame begins.
//  5. rst=0 for 1 cycle mid-digits:
//     -> tx_push=0, busy=0, done=0 from the next edge.
//     -> a later start produces a complete, correct frame.
//  6. SUPPRESS_ZERO=0, value=42 -> digits 30 30 30 34 32.

Source files
------------

// File: rtl/uart_ascii_sender.sv
// rtl/uart_ascii_sender.sv - formats a reading as "<tag>:<digits>\r\n" and pushes it into the UART TX FIFO
module uart_ascii_sender #(
  parameter int DATA_W        = 14,
  parameter int NUM_DIGITS    = 5,
  parameter int SUPPRESS_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        tag,
  input  logic [DATA_W-1:0] value,
  input  logic              tx_full,
  output logic              tx_push,
  output logic [7:0]        tx_push_data,
  output logic              busy,
  output logic              done
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(DATA_W - 1);
  localparam logic [PTR_W-1:0] PTR_TOP   = PTR_W'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_TAG, S_SEP, S_DIG, S_CR, S_LF
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        tag_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  ptr_q;
  logic              done_q;

  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;
  logic [PTR_W-1:0]  lead_ptr;
  logic [3:0]        cur_digit;
  logic              in_send;

  // Double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], shreg_q[DATA_W-1]};
  end

  // Most-significant non-zero digit of the final BCD result (digit 0 when all zero).
  always_comb begin
    lead_ptr = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        lead_ptr = PTR_W'(i);
      end
    end
  end

  // Select the digit currently addressed by the send pointer.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ptr_q == PTR_W'(i)) begin
        cur_digit = bcd_q[4*i +: 4];
      end
    end
  end

  // Next state and push outputs; send states advance only on an accepted push.
  always_comb begin
    state_d      = state_q;
    in_send      = 1'b0;
    tx_push_data = 8'h00;
    case (state_q)
      S_IDLE: if (start) state_d = S_CONV;
      S_CONV: if (cnt_q == CONV_LAST) state_d = S_TAG;
      S_TAG:  begin in_send = 1'b1; tx_push_data = tag_q;                    end
      S_SEP:  begin in_send = 1'b1; tx_push_data = 8'h3A;                    end
      S_DIG:  begin in_send = 1'b1; tx_push_data = 8'h30 + {4'h0, cur_digit}; end
      S_CR:   begin in_send = 1'b1; tx_push_data = 8'h0D;                    end
      S_LF:   begin in_send = 1'b1; tx_push_data = 8'h0A;                    end
      default: state_d = S_IDLE;
    endcase
    // Gated by rst so the cycle that aborts a frame cannot slip one more byte in.
    tx_push = in_send & ~tx_full & rst;
    if (tx_push) begin
      case (state_q)
        S_TAG:   state_d = S_SEP;
        S_SEP:   state_d = S_DIG;
        S_DIG:   if (ptr_q == '0) state_d = S_CR;
        S_CR:    state_d = S_LF;
        S_LF:    state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath: latch request, run the conversion, walk the digit pointer, flag completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q   <= '0;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_LF) && tx_push;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tag_q   <= tag;
            shreg_q <= value;
            bcd_q   <= '0;
            cnt_q   <= '0;
          end
        end
        S_CONV: begin
          bcd_q   <= bcd_shift;
          shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CONV_LAST) begin
            ptr_q <= (SUPPRESS_ZERO != 0) ? lead_ptr : PTR_TOP;
          end
        end
        S_DIG: begin
          if (tx_push && (ptr_q != '0)) ptr_q <= ptr_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule
